// File: rtl/pktunit_pkg.sv
// Shared types, constants and raw-socket back-end hooks for the packet-unit
// transmit blocks. The hooks are behavioural stand-ins that keep call counters
// and let the environment script send failures.
// The stats outputs of the arbiter are enabled with PKTUNIT_TX_STATS_EN.
package pktunit_pkg;

   typedef enum logic [2:0] {IDLE, STREAM, SEND, BACKOFF, DROP} tx_state_e;

   // Bit of the flags byte that marks a corrupted frame
   localparam int FLAG_ERR = 0;

   // Index width for a channel count, never narrower than one bit
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Stand-in back end: counts calls and lets the environment script failures.
   // A send fails while fewer than sim_fail_limit sends happened since
   // sim_fail_base was taken.
   int unsigned sim_put_cnt;
   int unsigned sim_send_cnt;
   int unsigned sim_drop_cnt;
   int unsigned sim_byte_sum;
   int          sim_last_rsh;
   int unsigned sim_fail_base;
   int unsigned sim_fail_limit;

   function automatic void dpiPutByte(input int rsh, input byte b);
      sim_last_rsh = rsh;
      sim_put_cnt  = sim_put_cnt + 1;
      sim_byte_sum = sim_byte_sum + {24'd0, b};
   endfunction

   function automatic bit dpiSendFrame(input int rsh);
      bit ok;
      sim_last_rsh = rsh;
      ok = (sim_send_cnt - sim_fail_base) >= sim_fail_limit;
      sim_send_cnt = sim_send_cnt + 1;
      return ok;
   endfunction

   function automatic void dpiDropFrame(input int rsh);
      sim_last_rsh = rsh;
      sim_drop_cnt = sim_drop_cnt + 1;
   endfunction

endpackage

// File: rtl/pktunit_rr_arb.sv
// Round-robin channel picker: first requesting channel at or after the
// rotating pointer, with the pointer moved past a channel on request.
module pktunit_rr_arb
   import pktunit_pkg::*;
#(
   parameter int NUM_CH = 4,
   localparam int GW = clog2_min1(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   input  logic [GW-1:0]     adv_from,
   output logic [GW-1:0]     gnt,
   output logic              found
);

   logic [GW-1:0] ptr;
   int            idx;

   // Scan from the farthest candidate back to the pointer so the nearest wins
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (req[GW'(idx)]) begin
            gnt   = GW'(idx);
            found = 1'b1;
         end
      end
   end

   // Pointer moves to the channel after the one that just finished a frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr <= '0;
      else if (advance) ptr <= (adv_from == GW'(NUM_CH - 1)) ? '0 : adv_from + 1'b1;
   end

endmodule

// File: rtl/pktunit_axis_tx_arb.sv
// Multi-channel packet-unit transmitter: picks a channel per frame in
// round-robin order, streams its bytes into the raw-socket buffer and sends
// the frame with spaced, bounded retries. Errored frames are discarded.
// Optional frame statistics outputs: define PKTUNIT_TX_STATS_EN.
module pktunit_axis_tx_arb
   import pktunit_pkg::*;
#(
   parameter int DATA_BYTES = 8,
   parameter int NUM_CH     = 4,
   parameter int MAX_RETRY  = 8,
   parameter int RETRY_GAP  = 4,
   localparam int GW = clog2_min1(NUM_CH)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  int                                   rsh,
   input  logic [NUM_CH-1:0][DATA_BYTES*8-1:0]  data_d,
   input  logic [NUM_CH-1:0]                    data_v,
   output logic [NUM_CH-1:0]                    data_r,
   input  logic [NUM_CH-1:0][7:0]               flags_d,
   input  logic [NUM_CH-1:0]                    flags_v,
   output logic [NUM_CH-1:0]                    flags_r,
   input  logic [NUM_CH-1:0][DATA_BYTES:0]      eop_d,
   input  logic [NUM_CH-1:0]                    eop_v,
   output logic [NUM_CH-1:0]                    eop_r,
   output logic [GW-1:0]                        grant,
   output logic                                 busy
`ifdef PKTUNIT_TX_STATS_EN
   ,
   output logic [31:0]                          frames_sent,
   output logic [31:0]                          frames_dropped,
   output logic [31:0]                          retries
`endif
);

   tx_state_e               state, next_state, fail_state;
   logic [NUM_CH-1:0]       ch_valid;
   logic [DATA_BYTES*8-1:0] sel_data;
   logic [7:0]              sel_flags;
   logic [DATA_BYTES:0]     sel_eop;
   logic                    acc, is_last, frame_err, err, flush, advance;
   logic                    arb_found;
   logic [GW-1:0]           arb_gnt;
   logic [31:0]             retry_cnt, gap_cnt;
   int                      last_idx;
   logic                    unused_flag_bits;

   assign ch_valid         = data_v & flags_v & eop_v;
   assign sel_data         = data_d[grant];
   assign sel_flags        = flags_d[grant];
   assign sel_eop          = eop_d[grant];
   assign frame_err        = sel_flags[FLAG_ERR];
   assign unused_flag_bits = ^sel_flags[7:1];
   assign is_last          = |sel_eop;
   assign acc              = (state == STREAM) && ch_valid[grant];
   assign advance          = acc && is_last;
   assign busy             = (state != IDLE);

   pktunit_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (ch_valid),
      .advance  (advance),
      .adv_from (grant),
      .gnt      (arb_gnt),
      .found    (arb_found)
   );

   // Only the granted channel sees ready, and only while streaming
   always_comb begin
      data_r = '0;
      if (state == STREAM) data_r[grant] = 1'b1;
      flags_r = data_r;
      eop_r   = data_r;
   end

   // Last byte index of the current unit: lowest eop bit, else the full unit
   always_comb begin
      last_idx = DATA_BYTES - 1;
      for (int i = DATA_BYTES - 1; i >= 0; i--) begin
         if (sel_eop[i]) last_idx = i;
      end
   end

   // Next state; SEND resolves here to the failure path, success is decided
   // where the send call is made
   always_comb begin
      next_state = state;
      fail_state = BACKOFF;
      if (MAX_RETRY != 0 && (retry_cnt + 32'd1) == 32'(MAX_RETRY)) fail_state = DROP;
      case (state)
         IDLE:    if (arb_found) next_state = STREAM;
         STREAM:  if (acc && is_last) next_state = (err || frame_err) ? DROP : SEND;
         SEND:    next_state = fail_state;
         BACKOFF: if (gap_cnt <= 32'd1) next_state = SEND;
         DROP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register plus the back-end calls, which must happen exactly once
   // per edge and whose send result steers the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         err       <= 1'b0;
         retry_cnt <= '0;
         gap_cnt   <= '0;
         flush     <= 1'b1;
`ifdef PKTUNIT_TX_STATS_EN
         frames_sent    <= '0;
         frames_dropped <= '0;
         retries        <= '0;
`endif
      end else begin
         state <= next_state;
         if (flush) begin
            dpiDropFrame(rsh);
            flush <= 1'b0;
         end
         case (state)
            IDLE: if (arb_found) grant <= arb_gnt;
            STREAM: begin
               if (acc) begin
                  for (int i = 0; i < DATA_BYTES; i++) begin
                     if (i <= last_idx) dpiPutByte(rsh, sel_data[i*8 +: 8]);
                  end
                  err <= err | frame_err;
               end
            end
            SEND: begin
               if (dpiSendFrame(rsh)) begin
                  state     <= IDLE;
                  retry_cnt <= '0;
`ifdef PKTUNIT_TX_STATS_EN
                  frames_sent <= frames_sent + 32'd1;
`endif
               end else begin
                  retry_cnt <= retry_cnt + 32'd1;
                  gap_cnt   <= 32'(RETRY_GAP);
`ifdef PKTUNIT_TX_STATS_EN
                  retries <= retries + 32'd1;
`endif
               end
            end
            BACKOFF: gap_cnt <= gap_cnt - 32'd1;
            DROP: begin
               dpiDropFrame(rsh);
               err       <= 1'b0;
               retry_cnt <= '0;
`ifdef PKTUNIT_TX_STATS_EN
               frames_dropped <= frames_dropped + 32'd1;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pktunit_axis_tx_arb.sv
// Directed bench for pktunit_axis_tx_arb: a per-cycle round-robin vector table
// followed by hand-written frame, retry, drop, error and reset sequences.
module tb_pktunit_axis_tx_arb;
   import pktunit_pkg::*;

   localparam int DB = 8;
   localparam int NC = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   int                      rsh;
   logic [NC-1:0][DB*8-1:0] data_d;
   logic [NC-1:0]           data_v, data_r;
   logic [NC-1:0][7:0]      flags_d;
   logic [NC-1:0]           flags_v, flags_r;
   logic [NC-1:0][DB:0]     eop_d;
   logic [NC-1:0]           eop_v, eop_r;
   logic [1:0]              grant;
   logic                    busy;
`ifdef PKTUNIT_TX_STATS_EN
   logic [31:0]             frames_sent, frames_dropped, retries;
`endif

   pktunit_axis_tx_arb #(.DATA_BYTES(DB), .NUM_CH(NC), .MAX_RETRY(3), .RETRY_GAP(4)) dut (
      .clk(clk), .rst(rst), .rsh(rsh),
      .data_d(data_d), .data_v(data_v), .data_r(data_r),
      .flags_d(flags_d), .flags_v(flags_v), .flags_r(flags_r),
      .eop_d(eop_d), .eop_v(eop_v), .eop_r(eop_r),
      .grant(grant), .busy(busy)
`ifdef PKTUNIT_TX_STATS_EN
      , .frames_sent(frames_sent), .frames_dropped(frames_dropped), .retries(retries)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] vmask;
      logic       exp_busy;
      logic [1:0] exp_grant;
      logic [3:0] exp_ready;
   } vec_t;

   vec_t        vecs[26];
   int          n_cmp = 0;
   int          n_fail = 0;
   int unsigned p0, s0, d0, b0;
   int          att[4];
   int          n_att, drop_edge;
   int unsigned prev_s, prev_d;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic snap();
      p0 = sim_put_cnt;
      s0 = sim_send_cnt;
      d0 = sim_drop_cnt;
      b0 = sim_byte_sum;
   endtask

   task automatic setValid(input logic [3:0] mask);
      data_v  = mask;
      flags_v = mask;
      eop_v   = mask;
   endtask

   function automatic logic [DB*8-1:0] unitData(input int u);
      logic [DB*8-1:0] r;
      for (int i = 0; i < DB; i++) r[i*8 +: 8] = 8'(u * 16 + i);
      return r;
   endfunction

   task automatic setUnit(input int ch, input int u, input logic [DB:0] eop, input logic flag);
      data_d[ch]  = unitData(u);
      eop_d[ch]   = eop;
      flags_d[ch] = {7'd0, flag};
   endtask

   // One-unit frames on every channel in vmask; channel c carries byte 8'hA0+c
   task automatic applyStimulus(input logic [3:0] vmask);
      for (int c = 0; c < NC; c++) begin
         data_d[c]  = {56'd0, 8'(8'hA0 + c)};
         eop_d[c]   = 9'h001;
         flags_d[c] = 8'h00;
      end
      setValid(vmask);
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic waitReady(input int ch);
      int k;
      k = 0;
      while (!data_r[ch] && k < 20) begin
         cycle();
         k++;
      end
      checkOutput($sformatf("ready_ch%0d", ch), longint'(data_r[ch]), 1);
   endtask

   // Watches send/drop calls for 14 edges after the last unit edge
   task automatic watchAttempts();
      n_att     = 0;
      drop_edge = -1;
      prev_s    = sim_send_cnt;
      prev_d    = sim_drop_cnt;
      for (int k = 1; k <= 14; k++) begin
         cycle();
         if (sim_send_cnt != prev_s && n_att < 4) begin
            att[n_att] = k;
            n_att++;
         end
         if (sim_drop_cnt != prev_d && drop_edge < 0) drop_edge = k;
         prev_s = sim_send_cnt;
         prev_d = sim_drop_cnt;
      end
   endtask

   initial begin
      vecs[0]  = '{4'hF, 1'b0, 2'd0, 4'h0};
      vecs[1]  = '{4'hF, 1'b1, 2'd0, 4'h1};
      vecs[2]  = '{4'hF, 1'b1, 2'd0, 4'h0};
      vecs[3]  = '{4'hF, 1'b0, 2'd0, 4'h0};
      vecs[4]  = '{4'hF, 1'b1, 2'd1, 4'h2};
      vecs[5]  = '{4'hF, 1'b1, 2'd1, 4'h0};
      vecs[6]  = '{4'hF, 1'b0, 2'd1, 4'h0};
      vecs[7]  = '{4'hF, 1'b1, 2'd2, 4'h4};
      vecs[8]  = '{4'hF, 1'b1, 2'd2, 4'h0};
      vecs[9]  = '{4'hF, 1'b0, 2'd2, 4'h0};
      vecs[10] = '{4'hF, 1'b1, 2'd3, 4'h8};
      vecs[11] = '{4'hF, 1'b1, 2'd3, 4'h0};
      vecs[12] = '{4'hF, 1'b0, 2'd3, 4'h0};
      vecs[13] = '{4'hF, 1'b1, 2'd0, 4'h1};
      vecs[14] = '{4'hF, 1'b1, 2'd0, 4'h0};
      vecs[15] = '{4'hA, 1'b0, 2'd0, 4'h0};
      vecs[16] = '{4'hA, 1'b1, 2'd1, 4'h2};
      vecs[17] = '{4'hA, 1'b1, 2'd1, 4'h0};
      vecs[18] = '{4'hA, 1'b0, 2'd1, 4'h0};
      vecs[19] = '{4'hA, 1'b1, 2'd3, 4'h8};
      vecs[20] = '{4'hA, 1'b1, 2'd3, 4'h0};
      vecs[21] = '{4'hA, 1'b0, 2'd3, 4'h0};
      vecs[22] = '{4'hA, 1'b1, 2'd1, 4'h2};
      vecs[23] = '{4'h0, 1'b1, 2'd1, 4'h0};
      vecs[24] = '{4'h0, 1'b0, 2'd1, 4'h0};
      vecs[25] = '{4'h0, 1'b0, 2'd1, 4'h0};

      rsh            = 7;
      sim_fail_base  = 0;
      sim_fail_limit = 0;
      rst            = 1'b1;
      applyStimulus(4'h0);

      // Reset state
      @(negedge clk);
      checkOutput("reset_busy", longint'(busy), 0);
      checkOutput("reset_grant", longint'(grant), 0);
      checkOutput("reset_ready", longint'(data_r | flags_r | eop_r), 0);
`ifdef PKTUNIT_TX_STATS_EN
      checkOutput("reset_stats", longint'(frames_sent | frames_dropped | retries), 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      snap();

      // Round-robin table, one row per cycle, outputs checked before the edge
      for (int i = 0; i < 26; i++) begin
         applyStimulus(vecs[i].vmask);
         checkOutput($sformatf("rr%0d_busy", i), longint'(busy), longint'(vecs[i].exp_busy));
         checkOutput($sformatf("rr%0d_grant", i), longint'(grant), longint'(vecs[i].exp_grant));
         checkOutput($sformatf("rr%0d_ready", i), longint'(data_r), longint'(vecs[i].exp_ready));
         cycle();
      end
      checkOutput("rr_puts", sim_put_cnt - p0, 8);
      checkOutput("rr_sends", sim_send_cnt - s0, 8);
      checkOutput("rr_flush_drop", sim_drop_cnt - d0, 1);
      checkOutput("rr_byte_sum", sim_byte_sum - b0, 1291);
      checkOutput("rr_rsh", sim_last_rsh, 7);

      // Three-unit frame on ch0, last unit keeps bytes 0..3
      snap();
      setUnit(0, 0, 9'h000, 1'b0);
      setValid(4'h1);
      waitReady(0);
      cycle();
      setUnit(0, 1, 9'h000, 1'b0);
      cycle();
      setUnit(0, 2, 9'b000001000, 1'b0);
      cycle();
      setValid(4'h0);
      checkOutput("f3_busy_n", longint'(busy), 1);
      checkOutput("f3_ready_n", longint'(data_r), 0);
      cycle();
      checkOutput("f3_busy_n1", longint'(busy), 0);
      checkOutput("f3_puts", sim_put_cnt - p0, 20);
      checkOutput("f3_sends", sim_send_cnt - s0, 1);
      checkOutput("f3_drops", sim_drop_cnt - d0, 0);
      checkOutput("f3_byte_sum", sim_byte_sum - b0, 318);

      // Two failed sends then success
      snap();
      sim_fail_base  = sim_send_cnt;
      sim_fail_limit = 2;
      setUnit(0, 3, 9'h001, 1'b0);
      setValid(4'h1);
      waitReady(0);
      cycle();
      setValid(4'h0);
      watchAttempts();
      checkOutput("retry_attempts", n_att, 3);
      checkOutput("retry_edge0", att[0], 1);
      checkOutput("retry_edge1", att[1], 6);
      checkOutput("retry_edge2", att[2], 11);
      checkOutput("retry_drops", sim_drop_cnt - d0, 0);
      checkOutput("retry_busy", longint'(busy), 0);

      // Sends always fail: dropped after MAX_RETRY attempts
      snap();
      sim_fail_base  = sim_send_cnt;
      sim_fail_limit = 32'hFFFF_FFFF;
      setUnit(0, 4, 9'h001, 1'b0);
      setValid(4'h1);
      waitReady(0);
      cycle();
      setValid(4'h0);
      watchAttempts();
      checkOutput("maxr_attempts", n_att, 3);
      checkOutput("maxr_edge2", att[2], 11);
      checkOutput("maxr_drop_edge", drop_edge, 12);
      checkOutput("maxr_busy", longint'(busy), 0);
      sim_fail_limit = 0;
      snap();
      setUnit(1, 5, 9'h001, 1'b0);
      setValid(4'h2);
      waitReady(1);
      cycle();
      setValid(4'h0);
      cycle();
      checkOutput("after_drop_sends", sim_send_cnt - s0, 1);
      checkOutput("after_drop_drops", sim_drop_cnt - d0, 0);

      // Error flag on the middle unit of a ch2 frame
      snap();
      setUnit(2, 6, 9'h000, 1'b0);
      setValid(4'h4);
      waitReady(2);
      cycle();
      setUnit(2, 7, 9'h000, 1'b1);
      cycle();
      setUnit(2, 8, 9'h001, 1'b0);
      cycle();
      setUnit(2, 9, 9'h001, 1'b0);
      setUnit(3, 10, 9'h001, 1'b0);
      setValid(4'hC);
      cycle();
      checkOutput("err_drops", sim_drop_cnt - d0, 1);
      checkOutput("err_sends", sim_send_cnt - s0, 0);
      checkOutput("err_busy", longint'(busy), 0);
      cycle();
      checkOutput("err_next_grant", longint'(grant), 3);
      checkOutput("err_next_ready", longint'(data_r), 8);
      cycle();
      setValid(4'h0);
      cycle();
      checkOutput("err_next_sends", sim_send_cnt - s0, 1);
`ifdef PKTUNIT_TX_STATS_EN
      checkOutput("stats_sent", longint'(frames_sent), 12);
      checkOutput("stats_dropped", longint'(frames_dropped), 2);
      checkOutput("stats_retries", longint'(retries), 5);
`endif

      // Reset during streaming, then a new frame
      setUnit(1, 11, 9'h000, 1'b0);
      setValid(4'h2);
      waitReady(1);
      cycle();
      cycle();
      checkOutput("rst_pre_ready", longint'(data_r), 2);
      rst = 1'b1;
      #1;
      checkOutput("rst_ready", longint'(data_r | flags_r | eop_r), 0);
      checkOutput("rst_busy", longint'(busy), 0);
      checkOutput("rst_grant", longint'(grant), 0);
      snap();
      @(negedge clk);
      rst = 1'b0;
      setUnit(1, 12, 9'h001, 1'b0);
      cycle();
      checkOutput("rst_flush_drop", sim_drop_cnt - d0, 1);
      checkOutput("rst_no_put_yet", sim_put_cnt - p0, 0);
      checkOutput("rst_new_ready", longint'(data_r), 2);
      cycle();
      setValid(4'h0);
      checkOutput("rst_new_put", sim_put_cnt - p0, 1);
      cycle();
      checkOutput("rst_new_send", sim_send_cnt - s0, 1);
`ifdef PKTUNIT_TX_STATS_EN
      checkOutput("rst_stats_sent", longint'(frames_sent), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
